// File: rtl/axi_slave_mem.sv
// AXI4 memory-backed slave: independent write (AW/W/B) and read (AR/R) engines
// sharing one word array, supporting FIXED/INCR/WRAP bursts with SLVERR reporting.
module axi_slave_mem #(
  parameter int unsigned ID_W      = 8,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic ax_err(input logic [7:0] len, input logic [2:0] size,
                                  input logic [1:0] burst);
    return (size > 3'd2) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok(len));
  endfunction

  // Illegal burst encodings and malformed WRAPs fall back to INCR addressing.
  function automatic logic [1:0] eff_burst(input logic [7:0] len, input logic [1:0] burst);
    if ((burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok(len))) return 2'b01;
    return burst;
  endfunction

  function automatic logic in_range(input logic [ADDR_W-3:0] word);
    return 32'(word) < MEM_DEPTH;
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [7:0] len,
                                                  input logic [2:0] size,
                                                  input logic [1:0] burst);
    logic [ADDR_W-1:0] step, sum, beats, bound;
    step  = ADDR_W'(1) << size;
    sum   = addr + step;
    beats = ADDR_W'(len) + ADDR_W'(1);
    bound = beats * step;
    case (burst)
      2'b00:   return addr;
      2'b10:   return (addr & ~(bound - ADDR_W'(1))) | (sum & (bound - ADDR_W'(1)));
      default: return sum;
    endcase
  endfunction

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // ---------------- write channel ----------------
  w_state_t          w_state, w_next;
  logic [ID_W-1:0]   aw_id;
  logic [ADDR_W-1:0] aw_addr;
  logic [7:0]        aw_len;
  logic [2:0]        aw_size;
  logic [1:0]        aw_burst;
  logic [8:0]        w_beat;
  logic              w_err;
  logic              aw_hs, w_hs, w_in_range;

  assign aw_hs      = s_axi_awvalid && s_axi_awready;
  assign w_hs       = s_axi_wvalid && s_axi_wready;
  assign w_in_range = in_range(aw_addr[ADDR_W-1:2]);

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next        = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    if (!rst) begin
      case (w_state)
        W_IDLE: begin
          s_axi_awready = 1'b1;
          if (s_axi_awvalid) w_next = W_DATA;
        end
        W_DATA: begin
          s_axi_wready = 1'b1;
          if (s_axi_wvalid && s_axi_wlast) w_next = W_RESP;
        end
        W_RESP: begin
          s_axi_bvalid = 1'b1;
          if (s_axi_bready) w_next = W_IDLE;
        end
        default: w_next = W_IDLE;
      endcase
    end
  end

  assign s_axi_bid   = s_axi_bvalid ? aw_id : '0;
  assign s_axi_bresp = (s_axi_bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_id    <= '0;
      aw_addr  <= '0;
      aw_len   <= '0;
      aw_size  <= '0;
      aw_burst <= '0;
      w_beat   <= '0;
      w_err    <= 1'b0;
    end else if (aw_hs) begin
      aw_id    <= s_axi_awid;
      aw_addr  <= s_axi_awaddr;
      aw_len   <= s_axi_awlen;
      aw_size  <= s_axi_awsize;
      aw_burst <= eff_burst(s_axi_awlen, s_axi_awburst);
      w_beat   <= '0;
      w_err    <= ax_err(s_axi_awlen, s_axi_awsize, s_axi_awburst);
    end else if (w_hs) begin
      // Error stays sticky across the burst so bresp reflects every beat.
      w_err   <= w_err | !w_in_range | (s_axi_wlast && (w_beat != {1'b0, aw_len}));
      aw_addr <= next_addr(aw_addr, aw_len, aw_size, aw_burst);
      w_beat  <= w_beat + 9'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && w_in_range) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (s_axi_wstrb[b]) mem[aw_addr[IDX_W+1:2]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t          r_state, r_next;
  logic [ID_W-1:0]   ar_id;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic [7:0]        r_beat;
  logic              ar_err;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              rlast_q;
  logic              ar_hs, r_hs, ld, ld_err, ld_in_range;
  logic [ADDR_W-1:0] ld_addr;

  assign ar_hs       = s_axi_arvalid && s_axi_arready;
  assign r_hs        = s_axi_rvalid && s_axi_rready;
  // A beat is fetched either on AR acceptance or when the current beat is taken.
  assign ld          = ar_hs || (r_hs && !rlast_q);
  assign ld_addr     = ar_hs ? s_axi_araddr : next_addr(ar_addr, ar_len, ar_size, ar_burst);
  assign ld_err      = ar_hs ? ax_err(s_axi_arlen, s_axi_arsize, s_axi_arburst) : ar_err;
  assign ld_in_range = in_range(ld_addr[ADDR_W-1:2]);

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next        = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    if (!rst) begin
      case (r_state)
        R_IDLE: begin
          s_axi_arready = 1'b1;
          if (s_axi_arvalid) r_next = R_DATA;
        end
        R_DATA: begin
          s_axi_rvalid = 1'b1;
          if (s_axi_rready && rlast_q) r_next = R_IDLE;
        end
        default: r_next = R_IDLE;
      endcase
    end
  end

  assign s_axi_rid   = s_axi_rvalid ? ar_id   : '0;
  assign s_axi_rdata = s_axi_rvalid ? rdata_q : '0;
  assign s_axi_rresp = s_axi_rvalid ? rresp_q : RESP_OKAY;
  assign s_axi_rlast = s_axi_rvalid && rlast_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_id    <= '0;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      ar_burst <= '0;
      ar_err   <= 1'b0;
      r_beat   <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
    end else begin
      if (ar_hs) begin
        ar_id    <= s_axi_arid;
        ar_len   <= s_axi_arlen;
        ar_size  <= s_axi_arsize;
        ar_burst <= eff_burst(s_axi_arlen, s_axi_arburst);
        ar_err   <= ld_err;
        r_beat   <= '0;
      end else if (r_hs) begin
        r_beat <= r_beat + 8'd1;
      end
      if (ld) begin
        ar_addr <= ld_addr;
        rdata_q <= ld_in_range ? mem[ld_addr[IDX_W+1:2]] : '0;
        rresp_q <= (ld_err || !ld_in_range) ? RESP_SLVERR : RESP_OKAY;
        rlast_q <= ar_hs ? (s_axi_arlen == 8'd0) : ((r_beat + 8'd1) == ar_len);
      end
    end
  end

endmodule
